// File: rtl/tdc_fifo_write_arbiter.sv
// rtl/tdc_fifo_write_arbiter.sv - round-robin FIFO write-port arbiter for NUM_CH TDC controllers
// One word per grant; done pulse returned only to the served channel.
module tdc_fifo_write_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 32,
  parameter int STALL_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_wr_en,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  output logic [NUM_CH-1:0]        req_done,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [DATA_W-1:0]        fifo_din,
  output logic                     busy,
  output logic [2:0]               last_grant,
  output logic [STALL_W-1:0]       full_stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  localparam logic [NUM_CH-1:0] ONE_CH = NUM_CH'(1);

  state_t              r_state;
  logic [NUM_CH-1:0]   r_req_done;
  logic                r_fifo_wr_en;
  logic [DATA_W-1:0]   r_fifo_din;
  logic                r_busy;
  logic [2:0]          r_last_grant;
  logic [STALL_W-1:0]  r_stall_cnt;
  logic [2:0]          r_rr_ptr;

  logic                w_any;
  logic                w_hi_found;
  logic [2:0]          w_hi;
  logic [2:0]          w_lo;
  logic [2:0]          w_grant;
  logic [DATA_W-1:0]   w_data;

  assign w_any = |req_wr_en;

  // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (req_wr_en[j]) begin
        w_lo = 3'(j);
        if (j >= int'(r_rr_ptr)) begin
          w_hi       = 3'(j);
          w_hi_found = 1'b1;
        end
      end
    end
    w_grant = w_hi_found ? w_hi : w_lo;
  end

  always_comb begin
    w_data = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (3'(j) == w_grant) begin
        w_data = req_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_req_done   <= '0;
      r_fifo_wr_en <= 1'b0;
      r_fifo_din   <= '0;
      r_busy       <= 1'b0;
      r_last_grant <= '0;
      r_stall_cnt  <= '0;
      r_rr_ptr     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any && !fifo_full) begin
            r_fifo_din   <= w_data;
            r_fifo_wr_en <= 1'b1;
            r_last_grant <= w_grant;
            r_rr_ptr     <= (w_grant == 3'(NUM_CH - 1)) ? 3'd0 : w_grant + 3'd1;
            r_busy       <= 1'b1;
            r_state      <= ST_WRITE;
          end else if (w_any && fifo_full && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
          end
        end
        ST_WRITE: begin
          r_fifo_wr_en <= 1'b0;
          r_req_done   <= ONE_CH << r_last_grant;
          r_state      <= ST_ACK;
        end
        ST_ACK: begin
          r_req_done <= '0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_done       = r_req_done;
  assign fifo_wr_en     = r_fifo_wr_en;
  assign fifo_din       = r_fifo_din;
  assign busy           = r_busy;
  assign last_grant     = r_last_grant;
  assign full_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_tdc_fifo_write_arbiter.sv
// tb/tb_tdc_fifo_write_arbiter.sv - directed scoreboard bench for tdc_fifo_write_arbiter
// Expected FIFO words are queued at stimulus time and popped on each fifo_wr_en.
module tb_tdc_fifo_write_arbiter;
  localparam int NUM_CH  = 2;
  localparam int DATA_W  = 32;
  localparam int STALL_W = 16;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        req_wr_en = '0;
  logic [NUM_CH*DATA_W-1:0] req_data = '0;
  logic [NUM_CH-1:0]        req_done;
  logic                     fifo_full = 1'b0;
  logic                     fifo_wr_en;
  logic [DATA_W-1:0]        fifo_din;
  logic                     busy;
  logic [2:0]               last_grant;
  logic [STALL_W-1:0]       full_stall_cnt;

  int          checks = 0;
  int          failures = 0;
  logic [34:0] sb[$];
  int          cyc = 0;
  int          busy_cyc = 0;
  int          last_wr_cyc = -100;
  int          wr_gap = 0;
  int          served[2];
  int          rearm[2];
  logic        pend_valid = 1'b0;
  logic        pend_rst = 1'b0;
  logic [2:0]  pend_ch = '0;

  tdc_fifo_write_arbiter #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .STALL_W(STALL_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_wr_en(req_wr_en),
    .req_data(req_data),
    .req_done(req_done),
    .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en),
    .fifo_din(fifo_din),
    .busy(busy),
    .last_grant(last_grant),
    .full_stall_cnt(full_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(int ch, logic [31:0] d);
    sb.push_back({3'(ch), d});
  endtask

  task automatic set_req(int ch, logic [31:0] d);
    req_data[ch*DATA_W +: DATA_W] = d;
    req_wr_en[ch] = 1'b1;
  endtask

  // Requester model plus scoreboard, run mid-cycle.
  task automatic monitor();
    logic [34:0] e;
    logic [1:0]  exp_done;
    logic [31:0] nd;
    exp_done = (pend_valid && !pend_rst) ? 2'(1 << pend_ch) : 2'b00;
    check("req_done", {62'd0, req_done}, {62'd0, exp_done});
    if (busy) busy_cyc++;
    for (int k = 0; k < NUM_CH; k++) begin
      if (req_done[k]) begin
        if (rearm[k] > 0) begin
          rearm[k]--;
          nd = 32'hC0DE_0000 + 32'(k * 256 + rearm[k]);
          req_data[k*DATA_W +: DATA_W] = nd;
          push(k, nd);
        end else begin
          req_wr_en[k] = 1'b0;
        end
      end
    end
    pend_valid = 1'b0;
    if (fifo_wr_en) begin
      check("write_expected", 64'(sb.size() != 0), 64'd1);
      pend_valid = 1'b1;
      pend_ch = last_grant;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("fifo_din", 64'(fifo_din), 64'(e[31:0]));
        check("last_grant", 64'(last_grant), 64'(e[34:32]));
        pend_ch = e[34:32];
        if (e[34:32] < 3'd2) served[int'(e[34:32])]++;
      end
      wr_gap = cyc - last_wr_cyc;
      last_wr_cyc = cyc;
    end
    pend_rst = rst;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    served = '{0, 0};
    rearm = '{0, 0};
    tick();
    tick();
    rst = 1'b0;
    check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    check("rst_done", 64'(req_done), 64'd0);
    check("rst_din", 64'(fifo_din), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_last_grant", 64'(last_grant), 64'd0);
    check("rst_stall", 64'(full_stall_cnt), 64'd0);

    busy_cyc = 0;
    push(0, 32'h1234_05D0);
    set_req(0, 32'h1234_05D0);
    repeat (6) tick();
    check("single_busy_cycles", 64'(busy_cyc), 64'd2);
    check("single_served", 64'(served[0]), 64'd1);

    rst_pulse();
    served = '{0, 0};
    push(0, 32'hAAAA_0001);
    push(1, 32'hBBBB_0002);
    set_req(0, 32'hAAAA_0001);
    set_req(1, 32'hBBBB_0002);
    repeat (8) tick();
    check("simul_gap", 64'(wr_gap), 64'd3);
    check("simul_served1", 64'(served[1]), 64'd1);

    served = '{0, 0};
    rearm = '{4, 4};
    push(0, 32'hC0DE_0F00);
    push(1, 32'hC0DE_0F01);
    set_req(0, 32'hC0DE_0F00);
    set_req(1, 32'hC0DE_0F01);
    repeat (40) tick();
    check("fair_ch0", 64'(served[0]), 64'd5);
    check("fair_ch1", 64'(served[1]), 64'd5);
    check("fair_sb_empty", 64'(sb.size()), 64'd0);

    rst_pulse();
    fifo_full = 1'b1;
    push(1, 32'hBEEF_0001);
    set_req(1, 32'hBEEF_0001);
    repeat (7) tick();
    check("bp_stall", 64'(full_stall_cnt), 64'd7);
    fifo_full = 1'b0;
    tick();
    check("bp_wr_next_edge", 64'(fifo_wr_en), 64'd1);
    repeat (3) tick();
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    push(0, 32'h0D0D_0004);
    push(0, 32'h0D0D_0004);
    set_req(0, 32'h0D0D_0004);
    tick();
    check("mid_in_write", 64'(fifo_wr_en), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_wr_en", 64'(fifo_wr_en), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_din", 64'(fifo_din), 64'd0);
    check("mid_last_grant", 64'(last_grant), 64'd0);
    tick();
    check("mid_regrant", 64'(fifo_wr_en), 64'd1);
    check("mid_regrant_din", 64'(fifo_din), 64'h0D0D_0004);
    repeat (3) tick();
    check("mid_sb_empty", 64'(sb.size()), 64'd0);

    fifo_full = 1'b1;
    set_req(1, 32'hDEAD_0002);
    repeat (3) tick();
    req_wr_en[1] = 1'b0;
    tick();
    fifo_full = 1'b0;
    repeat (4) tick();
    check("wd_stall", 64'(full_stall_cnt), 64'd3);

    fifo_full = 1'b1;
    push(0, 32'h5A5A_0003);
    set_req(0, 32'h5A5A_0003);
    repeat (65540) tick();
    check("sat_stall", 64'(full_stall_cnt), 64'hFFFF);
    fifo_full = 1'b0;
    repeat (4) tick();
    check("sat_hold", 64'(full_stall_cnt), 64'hFFFF);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
